// File: rtl/mesi_isc_cbus_snoop_agent_if.sv
// Bundle for the snoop agent: cbus command/ack, main-bus write-back and local fill path.
// slave = agent side, master = controller/bench side.
interface mesi_isc_cbus_snoop_agent_if #(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned CBUS_CMD_WIDTH = 3,
   parameter int unsigned MBUS_CMD_WIDTH = 3
);
   logic [CBUS_CMD_WIDTH-1:0] cbus_cmd_i;
   logic [ADDR_WIDTH-1:0]     cbus_addr_i;
   logic                      cbus_ack_o;
   logic [MBUS_CMD_WIDTH-1:0] mbus_cmd_o;
   logic [ADDR_WIDTH-1:0]     mbus_addr_o;
   logic                      mbus_ack_i;
   logic                      fill_valid_i;
   logic [ADDR_WIDTH-1:0]     fill_addr_i;
   logic [1:0]                fill_state_i;
   logic                      fill_ready_o;
   logic                      busy_o;

   modport slave (
      input  cbus_cmd_i, cbus_addr_i, mbus_ack_i, fill_valid_i, fill_addr_i, fill_state_i,
      output cbus_ack_o, mbus_cmd_o, mbus_addr_o, fill_ready_o, busy_o
   );

   modport master (
      output cbus_cmd_i, cbus_addr_i, mbus_ack_i, fill_valid_i, fill_addr_i, fill_state_i,
      input  cbus_ack_o, mbus_cmd_o, mbus_addr_o, fill_ready_o, busy_o
   );
endinterface

// File: rtl/mesi_isc_cbus_snoop_agent.sv
// Per-port cbus snoop responder with a direct-mapped MESI line table and Modified write-back.
// Optional MESI_ISC_SNOOP_STATS_EN adds saturating snoop-hit and write-back counters.
module mesi_isc_cbus_snoop_agent #(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned CBUS_CMD_WIDTH = 3,
   parameter int unsigned MBUS_CMD_WIDTH = 3,
   parameter int unsigned LINE_IDX_W     = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   mesi_isc_cbus_snoop_agent_if.slave bus
`ifdef MESI_ISC_SNOOP_STATS_EN
   ,
   output logic [15:0]                snoop_hit_cnt_o,
   output logic [15:0]                wb_cnt_o
`endif
);

   localparam int unsigned Lines = 1 << LINE_IDX_W;

   localparam logic [CBUS_CMD_WIDTH-1:0] CmdNop     = CBUS_CMD_WIDTH'(0);
   localparam logic [CBUS_CMD_WIDTH-1:0] CmdWrSnoop = CBUS_CMD_WIDTH'(1);
   localparam logic [CBUS_CMD_WIDTH-1:0] CmdRdSnoop = CBUS_CMD_WIDTH'(2);
   localparam logic [CBUS_CMD_WIDTH-1:0] CmdEnWr    = CBUS_CMD_WIDTH'(3);
   localparam logic [CBUS_CMD_WIDTH-1:0] CmdEnRd    = CBUS_CMD_WIDTH'(4);
   localparam logic [MBUS_CMD_WIDTH-1:0] MbusNop    = MBUS_CMD_WIDTH'(0);
   localparam logic [MBUS_CMD_WIDTH-1:0] MbusWr     = MBUS_CMD_WIDTH'(1);

   localparam logic [1:0] MesiI = 2'd0;
   localparam logic [1:0] MesiS = 2'd1;
   localparam logic [1:0] MesiE = 2'd2;
   localparam logic [1:0] MesiM = 2'd3;

   typedef enum logic [2:0] {StIdle, StLookup, StWb, StAck, StWaitNop} state_e;

   state_e                    r_state, w_state_d;
   logic [CBUS_CMD_WIDTH-1:0] r_cmd;
   logic [ADDR_WIDTH-1:0]     r_addr;
   logic [ADDR_WIDTH-1:0]     r_tag  [Lines];
   logic [1:0]                r_mesi [Lines];
   logic                      r_ack, r_busy;
   logic [MBUS_CMD_WIDTH-1:0] r_mbus_cmd;
   logic [ADDR_WIDTH-1:0]     r_mbus_addr;

   logic [LINE_IDX_W-1:0]     w_idx, w_fill_idx;
   logic                      w_hit, w_cmd_valid, w_fill_ready, w_upd_en;
   logic [1:0]                w_upd_mesi;

   assign w_idx       = r_addr[LINE_IDX_W-1:0];
   assign w_fill_idx  = bus.fill_addr_i[LINE_IDX_W-1:0];
   assign w_hit       = (r_tag[w_idx] == r_addr) && (r_mesi[w_idx] != MesiI);
   assign w_cmd_valid = (bus.cbus_cmd_i != CmdNop) && (bus.cbus_cmd_i <= CmdEnRd);
   // Any non-NOP command, even an undefined one, blocks the fill for this cycle.
   assign w_fill_ready = (r_state == StIdle) && (bus.cbus_cmd_i == CmdNop);

   always_comb begin
      w_state_d  = r_state;
      w_upd_en   = 1'b0;
      w_upd_mesi = MesiI;
      unique case (r_state)
         StIdle: if (w_cmd_valid) w_state_d = StLookup;
         StLookup: begin
            w_state_d = StAck;
            if (r_cmd == CmdWrSnoop) begin
               if (w_hit && r_mesi[w_idx] == MesiM) w_state_d = StWb;
               else if (w_hit) w_upd_en = 1'b1;
            end else if (r_cmd == CmdRdSnoop) begin
               if (w_hit && r_mesi[w_idx] == MesiM) w_state_d = StWb;
               else if (w_hit && r_mesi[w_idx] == MesiE) begin
                  w_upd_en   = 1'b1;
                  w_upd_mesi = MesiS;
               end
            end else begin
               w_upd_en   = 1'b1;
               w_upd_mesi = (r_cmd == CmdEnWr) ? MesiM : MesiS;
            end
         end
         StWb: if (bus.mbus_ack_i) begin
            w_state_d  = StAck;
            w_upd_en   = 1'b1;
            w_upd_mesi = (r_cmd == CmdWrSnoop) ? MesiI : MesiS;
         end
         StAck:     w_state_d = StWaitNop;
         StWaitNop: if (bus.cbus_cmd_i == CmdNop) w_state_d = StIdle;
         default:   w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= StIdle;
         r_cmd       <= CmdNop;
         r_addr      <= '0;
         r_ack       <= 1'b0;
         r_busy      <= 1'b0;
         r_mbus_cmd  <= MbusNop;
         r_mbus_addr <= '0;
      end else begin
         r_state     <= w_state_d;
         r_ack       <= (w_state_d == StAck);
         r_busy      <= (w_state_d != StIdle);
         r_mbus_cmd  <= (w_state_d == StWb) ? MbusWr : MbusNop;
         r_mbus_addr <= (w_state_d == StWb) ? r_addr : '0;
         if (r_state == StIdle && w_cmd_valid) begin
            r_cmd  <= bus.cbus_cmd_i;
            r_addr <= bus.cbus_addr_i;
         end
      end
   end

   // Protocol updates happen only outside IDLE and fills only in IDLE, so they never collide.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < Lines; i++) begin
            r_tag[i]  <= '0;
            r_mesi[i] <= MesiI;
         end
      end else if (w_upd_en) begin
         r_tag[w_idx]  <= r_addr;
         r_mesi[w_idx] <= w_upd_mesi;
      end else if (bus.fill_valid_i && w_fill_ready) begin
         r_tag[w_fill_idx]  <= bus.fill_addr_i;
         r_mesi[w_fill_idx] <= bus.fill_state_i;
      end
   end

   assign bus.cbus_ack_o   = r_ack;
   assign bus.busy_o       = r_busy;
   assign bus.mbus_cmd_o   = r_mbus_cmd;
   assign bus.mbus_addr_o  = r_mbus_addr;
   assign bus.fill_ready_o = w_fill_ready;

`ifdef MESI_ISC_SNOOP_STATS_EN
   logic r_unused_en_cmd;
   logic w_hit_inc, w_wb_inc;
   logic [15:0] r_hit_cnt, r_wb_cnt;

   assign w_hit_inc = (r_state == StLookup) && w_hit &&
                      ((r_cmd == CmdWrSnoop) || (r_cmd == CmdRdSnoop));
   assign w_wb_inc  = (r_state == StWb) && bus.mbus_ack_i;
   assign r_unused_en_cmd = 1'b0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_hit_cnt <= '0;
         r_wb_cnt  <= '0;
      end else begin
         if (w_hit_inc && r_hit_cnt != 16'hFFFF) r_hit_cnt <= r_hit_cnt + 16'd1;
         if (w_wb_inc && r_wb_cnt != 16'hFFFF) r_wb_cnt <= r_wb_cnt + 16'd1;
      end
   end

   assign snoop_hit_cnt_o = r_hit_cnt;
   assign wb_cnt_o        = r_wb_cnt;
`endif

endmodule
